// File: rtl/vga_glyph_pipe.sv
// Text-mode glyph pixel pipeline: S1 forms the text RAM address, S2 the font ROM address,
// S3 selects the pixel. Sync inputs ride alongside so all outputs share one latency.
module vga_glyph_pipe #(
   parameter int GLYPHS       = 80,
   parameter int ROWS         = 25,
   parameter int PIXELS       = 10,
   parameter int LINES        = 16,
   parameter int CURSOR_FIRST = 13,
   parameter int BLINK_LOG2   = 5,
   localparam int GW = $clog2(GLYPHS),
   localparam int RW = $clog2(ROWS),
   localparam int PW = $clog2(PIXELS),
   localparam int LW = $clog2(LINES),
   localparam int AW = $clog2(GLYPHS*ROWS),
   localparam int FW = 7 + LW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce,
   input  logic          h_active,
   input  logic          h_sync,
   input  logic [GW-1:0] h_glyph,
   input  logic [PW-1:0] h_pixel,
   input  logic          v_active,
   input  logic          v_sync,
   input  logic [RW-1:0] v_glyph,
   input  logic [LW-1:0] v_pixel,
   input  logic          frame,
   input  logic          cursor_en,
   input  logic [GW-1:0] cursor_col,
   input  logic [RW-1:0] cursor_row,
   output logic [AW-1:0] text_addr,
   input  logic [7:0]    text_data,
   output logic [FW-1:0] font_addr,
   input  logic [7:0]    font_data,
   output logic          video,
   output logic          hsync_out,
   output logic          vsync_out
);

   typedef struct packed {
      logic          active;
      logic          cur;
      logic          hs;
      logic          vs;
      logic [PW-1:0] hpix;
   } side_t;

   // Syncs idle high through the pipe so a refill after reset never emits a false sync pulse.
   localparam side_t SIDE_RST = '{active: 1'b0, cur: 1'b0, hs: 1'b1, vs: 1'b1, hpix: '0};
   localparam logic [LW:0] CF = (LW+1)'(CURSOR_FIRST);

   logic [BLINK_LOG2-1:0] r_blink;
   logic                  w_blink_on;
   logic                  w_cur_hit;
   logic                  w_bit;
   logic [AW-1:0]         w_addr;

   logic [AW-1:0]         r_s1_addr;
   logic [LW-1:0]         r_s1_vpix;
   side_t                 r_s1;

   logic [FW-1:0]         r_s2_faddr;
   logic                  r_s2_inv;
   side_t                 r_s2;

   logic                  r_video;
   logic                  r_hs;
   logic                  r_vs;

   // Blink runs on frame strobes alone; pixel enable has no say in it.
   always_ff @(posedge clk) begin
      if (reset)
         r_blink <= '0;
      else if (frame)
         r_blink <= r_blink + BLINK_LOG2'(1);
   end

   assign w_blink_on = r_blink[BLINK_LOG2-1];
   assign w_addr     = AW'(v_glyph) * AW'(GLYPHS) + AW'(h_glyph);
   assign w_cur_hit  = cursor_en & w_blink_on & (h_glyph == cursor_col) &
                       (v_glyph == cursor_row) & ({1'b0, v_pixel} >= CF);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_addr <= '0;
         r_s1_vpix <= '0;
         r_s1      <= SIDE_RST;
      end else if (ce) begin
         r_s1_addr   <= w_addr;
         r_s1_vpix   <= v_pixel;
         r_s1.active <= h_active & v_active;
         r_s1.cur    <= w_cur_hit;
         r_s1.hs     <= h_sync;
         r_s1.vs     <= v_sync;
         r_s1.hpix   <= h_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s2_faddr <= '0;
         r_s2_inv   <= 1'b0;
         r_s2       <= SIDE_RST;
      end else if (ce) begin
         r_s2_faddr <= {text_data[6:0], r_s1_vpix};
         r_s2_inv   <= text_data[7];
         r_s2       <= r_s1;
      end
   end

   // Columns past the 8-pixel font row are gap; 7-x on 3 bits is ~x.
   assign w_bit = ({1'b0, r_s2.hpix} < (PW+1)'(8)) ? font_data[~r_s2.hpix[2:0]] : 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_video <= 1'b0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
      end else if (ce) begin
         r_video <= r_s2.active & (w_bit ^ r_s2_inv ^ r_s2.cur);
         r_hs    <= r_s2.hs;
         r_vs    <= r_s2.vs;
      end
   end

   assign text_addr = r_s1_addr;
   assign font_addr = r_s2_faddr;
   assign video     = r_video;
   assign hsync_out = r_hs;
   assign vsync_out = r_vs;

endmodule
